// File: rtl/dcache_write_buffer.sv
// Posted store buffer between writeback and the data-cache array.
// Drains entries in FIFO order as 8-byte chunk writes; boundary-crossing stores take two chunks.
module dcache_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_v_i,
  input  logic [31:0] wr_address_i,
  input  logic [63:0] wr_data_i,
  input  logic [1:0]  wr_size_i,
  output logic        wr_ready_o,
  output logic        mem_req_o,
  output logic [28:0] mem_addr_o,
  output logic [63:0] mem_data_o,
  output logic [7:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] fwd_addr_i,
  output logic        fwd_hit_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;

  logic [31:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             push, pop;

  function automatic logic [3:0] nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [15:0] m;
    m = (16'd1 << nbytes(size)) - 16'd1;
    return m[7:0];
  endfunction

  function automatic logic is_split(input logic [31:0] addr, input logic [1:0] size);
    return ({1'b0, addr[2:0]} + nbytes(size)) > 4'd8;
  endfunction

  assign wr_ready_o = (count_q != CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push       = wr_v_i & wr_ready_o;

  // Head entry chunk formatting
  logic [31:0] h_addr;
  logic [63:0] h_data;
  logic [1:0]  h_size;
  logic [2:0]  h_off;
  logic        h_split;
  logic [7:0]  h_mask;
  logic [15:0] lo_be16;

  assign h_addr  = addr_q[head_q];
  assign h_data  = data_q[head_q];
  assign h_size  = size_q[head_q];
  assign h_off   = h_addr[2:0];
  assign h_split = is_split(h_addr, h_size);
  assign h_mask  = size_mask(h_size);
  assign lo_be16 = {8'b0, h_mask} << h_off;

  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_be_o   = '0;
    if (state_q == ST_LO) begin
      mem_req_o  = 1'b1;
      mem_addr_o = h_addr[31:3];
      mem_data_o = h_data << {h_off, 3'b000};
      mem_be_o   = lo_be16[7:0];
    end else if (state_q == ST_HI) begin
      mem_req_o  = 1'b1;
      mem_addr_o = h_addr[31:3] + 29'd1;
      mem_data_o = h_data >> (7'd64 - {1'b0, h_off, 3'b000});
      mem_be_o   = h_mask >> (4'd8 - {1'b0, h_off});
    end
  end

  // Drain sequencing and occupancy
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (count_q != '0) state_d = ST_LO;
      ST_LO: begin
        if (mem_ack_i) begin
          if (h_split) state_d = ST_HI;
          else         pop     = 1'b1;
        end
      end
      ST_HI: if (mem_ack_i) pop = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    if (pop) state_d = (count_d != '0) ? ST_LO : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= wr_address_i;
      data_q[tail_q] <= wr_data_i;
      size_q[tail_q] <= wr_size_i;
    end
  end

  // Load-overlap check against every occupied entry, lo and hi chunks alike
  logic [PTR_W-1:0] rel;
  logic [28:0]      fwd_chunk;
  logic             unused_fwd_lsb;

  assign fwd_chunk      = fwd_addr_i[31:3];
  assign unused_fwd_lsb = ^fwd_addr_i[2:0];

  always_comb begin
    fwd_hit_o = 1'b0;
    rel       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head_q;
      if ({1'b0, rel} < count_q) begin
        if ((fwd_chunk == addr_q[i][31:3]) ||
            (is_split(addr_q[i], size_q[i]) && (fwd_chunk == addr_q[i][31:3] + 29'd1)))
          fwd_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Posted write buffer on the data-cache write port. It is the responder for the writeback stage's store interface: it accepts validated store requests (address, 64-bit data, datasize), returns the write-ready indication the writeback stage uses to stall, and drains entries in FIFO order to the cache data array as 8-byte-aligned chunk writes with byte enables. Stores that cross an 8-byte boundary are split into two chunk writes. It also reports a load-overlap hit so the memory stage can hold loads behind pending stores.

## Interface
- DEPTH, 4, buffer entries; power of two, ≥2
- CLK  in  1  clock; all state updates on rising edge
- CLR  in  1  reset, asynchronous, active-low
- WR_V  in  1  store request valid (validated dcache-write from writeback)
- WR_ADDRESS  in  32  store byte address
- WR_DATA  in  64  store data, right-justified; upper bits ignored per size
- WR_SIZE  in  2  00 byte, 01 word, 10 dword, 11 qword (MM)
- WR_READY  out  1  buffer can accept this cycle
- MEM_REQ  out  1  chunk write request to cache array
- MEM_ADDR  out  29  chunk address (byte address [31:3])
- MEM_DATA  out  64  chunk data, lane-aligned
- MEM_BE  out  8  byte enables, bit i = byte lane i
- MEM_ACK  in  1  chunk write accepted
- FWD_ADDR  in  32  load address to check
- FWD_HIT  out  1  a buffered store touches FWD_ADDR's 8-byte chunk
- EMPTY  out  1  no buffered stores

## Operation
- Storage: DEPTH entries of {addr[31:0], data[63:0], size[1:0]}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- WR_READY = (count != DEPTH), derived from registered count only. Push when WR_V & WR_READY at the clock edge. Full with a same-cycle pop still refuses the push.
- Byte count n: 1/2/4/8 for size 00/01/10/11. off = addr[2:0]. mask = (1<<n)-1 (8 bits).
- Lo chunk: MEM_ADDR = addr[31:3], MEM_BE = (mask<<off)[7:0], MEM_DATA = data<<(8*off) truncated to 64 bits.
- Split when off+n > 8. Hi chunk: MEM_ADDR = addr[31:3]+1 (wraps mod 2^29), MEM_BE = mask>>(8-off), MEM_DATA = data>>(64-8*off).
- Drain FSM:
  - IDLE: MEM_REQ=0. Go to LO when count != 0.
  - LO: MEM_REQ=1 with the head's lo chunk. On MEM_ACK: split → HI. Otherwise pop head; go to LO if count after pop != 0, else IDLE.
  - HI: MEM_REQ=1 with the hi chunk. On MEM_ACK: pop head; next state as above.
- MEM_ADDR, MEM_DATA and MEM_BE are held stable while MEM_REQ=1 and no ack has been taken. Drained chunks are back-to-back: the next chunk's request is asserted in the cycle after an ack.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- FWD_HIT (combinational): OR over valid entries of (FWD_ADDR[31:3] == lo chunk addr) | (split & FWD_ADDR[31:3] == hi chunk addr). An entry remains valid, including its already-written lo half, until it is popped. A same-cycle incoming WR_V is not checked.
- EMPTY = (count == 0).

## Timing
- Reset (CLR low, asynchronous): count=0, pointers=0, FSM=IDLE. Outputs: WR_READY=1, EMPTY=1, MEM_REQ=0, FWD_HIT=0, MEM_ADDR/MEM_DATA/MEM_BE=0.
- Reset mid-drain: MEM_REQ drops immediately and all buffered stores are discarded. An ACK arriving in the same cycle is ignored.
- Push-to-request latency: a store pushed at edge k into an empty buffer gives MEM_REQ=1 after edge k+1. With zero-wait ACK, the entry pops at edge k+2 (unsplit) or k+3 (split).
- WR_READY deasserts in the cycle after the push that fills the buffer. It reasserts in the cycle after the pop that makes room.
- MEM_ACK is only meaningful while MEM_REQ=1; ACK with MEM_REQ=0 is ignored.

## Test plan
- Reset: pulse CLR low mid-cycle → WR_READY=1, EMPTY=1, MEM_REQ=0 immediately, with no clock edge needed.
- Aligned dword: push addr 0x00001000, data 0xDEADBEEF, size 10; ACK 2 cycles after REQ → one request with MEM_ADDR=0x0000200, MEM_BE=0x0F, MEM_DATA=0x00000000DEADBEEF, held for 2 cycles. EMPTY=1 after the ack edge.
- Split dword: push addr 0x00001006, data 0x11223344 → chunk 1: MEM_ADDR=0x0000200, BE=0xC0, MEM_DATA[63:48]=0x3344. Chunk 2: MEM_ADDR=0x0000201, BE=0x03, MEM_DATA[15:0]=0x1122.
- Full: MEM_ACK=0, push 4 stores → WR_READY=0 after the 4th; a 5th WR_V is held off. One ACK → WR_READY=1 next cycle; the 5th store is accepted; FIFO order is preserved on drain.
- Forward hit: buffered byte store at 0x00002004 → FWD_ADDR 0x00002000 gives FWD_HIT=1, 0x00002008 gives 0. For split store 0x00002006 size 10, FWD_ADDR 0x00002008 gives 1 until the pop, then 0.
- Qword MM with off=7: push addr 0x0000300F, data 0x8877665544332211 → lo BE=0x80, data byte7=0x11. Hi BE=0x7F, MEM_DATA=0x0088776655443322. CLR low during HI → MEM_REQ=0 and EMPTY=1 immediately.
